// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle datapath through fetch, decode, memory, ALU and branch steps
//   clk, rst_n         clock, asynchronous active-low reset
//   opcode             instruction bits [6:0]
//   mem_ready          memory handshake, access completes when 1
//   pc_write .. alu_op datapath control strobes and selects
//   trap               sticky illegal-opcode / memory-timeout flag
//   instr_count        retired-instruction counter, wraps
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WW = $clog2(WAIT_LIMIT + 2);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, EXEC_I, ALUWB, BRANCH, TRAP
    } state_t;

    state_t        state, nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          waiting, timeout, retire;

    assign waiting = state inside {FETCH, MEMRD, MEMWR};
    assign timeout = waiting && !mem_ready && wcnt == WW'(WAIT_LIMIT);
    assign retire  = nxt == FETCH && state inside {MEMWR, MEMWB, ALUWB, BRANCH};

    always_comb begin
        nxt = state;
        case (state)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE:
                case (opcode)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011:             nxt = EXEC_R;
                    7'b0010011:             nxt = EXEC_I;
                    7'b1100011:             nxt = BRANCH;
                    default:                nxt = TRAP;
                endcase
            MEMADR:  nxt = opcode == 7'b0100011 ? MEMWR : MEMRD;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            MEMWB, ALUWB, BRANCH: nxt = FETCH;
            EXEC_R, EXEC_I:       nxt = ALUWB;
            default: nxt = TRAP;
        endcase
        if (timeout) nxt = TRAP;
        // staying put in a wait state implies mem_ready=0; any move restarts the count
        wcnt_nxt = (waiting && nxt == state) ? wcnt + 1'b1 : '0;
    end

    // outputs are forced low while reset is held so an aborted access emits nothing
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        trap          = 1'b0;
        if (rst_n)
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'b10;
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                ALUWB:  reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                end
                default: trap = 1'b1;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            wcnt        <= '0;
            instr_count <= '0;
        end else begin
            state <= nxt;
            wcnt  <= wcnt_nxt;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end
endmodule
